dspctl_gen: RTL and testbench

- Parametrised dispatch control for the microsequencer.
- Latches the dispatch constant on a dispatch fetch and generates a variable-width byte mask from a length field.
- Forms the registered dispatch-memory address from that constant ORed with the masked source bits.
- Sequences dispatch-memory writes through a req/ack handshake, stalling the pipeline while a write is pending.
- Sits between instruction decode and the dispatch RAM.

---
 rtl/dspctl_pkg.sv | 24 ++
 rtl/dspctl_wrseq.sv | 71 +++++++
 rtl/dspctl_gen.sv | 121 ++++++++++++
 tb/tb_dspctl_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dspctl_pkg.sv
// Shared types and helpers for the dispatch control block.
package dspctl_pkg;

  // Write-sequencer states: idle, or holding a dispatch-memory write request.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WREQ = 1'b1
  } wr_state_e;

  // Bit of the dispatch function field that selects a write-dispatch.
  localparam int FUNCT_WR_BIT = 2;

  // Byte mask of 'len' ones. The mask saturates to mask_w ones once len reaches mask_w.
  function automatic logic [31:0] mask_of(input int unsigned len, input int unsigned mask_w);
    logic [31:0] m;
    if (len >= mask_w) begin
      m = (mask_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << mask_w) - 32'h1);
    end else begin
      m = (32'h1 << len) - 32'h1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dspctl_wrseq.sv
// Dispatch-memory write sequencer.
// It latches the address and data, then holds req/stall until the RAM acks.
module dspctl_wrseq
  import dspctl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              ack,
  output logic              busy,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              stall
);

  wr_state_e         state_q;
  logic              req_q;
  logic              stall_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Write FSM.
  // An ack seen in IDLE is ignored.
  // The address and data only change when a new write is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      stall_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WREQ;
            req_q   <= 1'b1;
            stall_q <= 1'b1;
            addr_q  <= addr;
            data_q  <= data;
          end
        end
        WREQ: begin
          if (ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state_q == WREQ);
  assign wr_req  = req_q;
  assign stall   = stall_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: rtl/dspctl_gen.sv
// Dispatch control for the microsequencer. It has three jobs:
// - latch the dispatch constant and the length mask;
// - form the registered dispatch address;
// - hand write-dispatches to the write sequencer.
module dspctl_gen
  import dspctl_pkg::*;
#(
  parameter int DC_W   = 10,
  parameter int MASK_W = 7,
  parameter int LEN_W  = 3,
  parameter int SRC_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              state_fetch,
  input  logic              irdisp,
  input  logic [3:0]        funct,
  input  logic [DC_W-1:0]   dc_field,
  input  logic [LEN_W-1:0]  len_field,
  input  logic [1:0]        map_sel,
  input  logic [SRC_W-1:0]  src,
  input  logic [SRC_W-1:0]  wr_data,
  input  logic              dmem_wr_ack,
  output logic [DC_W-1:0]   dc,
  output logic [MASK_W-1:0] dmask,
  output logic              dmapbenb,
  output logic [DC_W-1:0]   disp_addr,
  output logic              disp_valid,
  output logic              dmem_wr_req,
  output logic [DC_W-1:0]   dmem_wr_addr,
  output logic [SRC_W-1:0]  dmem_wr_data,
  output logic              stall,
  output logic              err_ovr
);

  logic [DC_W-1:0]   dc_q, dc_d;
  logic [MASK_W-1:0] dmask_q, dmask_d;
  logic [DC_W-1:0]   disp_addr_q, disp_addr_d;
  logic              disp_valid_q, disp_valid_d;
  logic              err_ovr_q, err_ovr_d;

  logic              ev;
  logic              busy;
  logic              ev_accept;
  logic              wr_start;
  logic [31:0]       mask_full;
  logic [MASK_W-1:0] mask;
  logic [DC_W-1:0]   addr;

  // The source bits above the mask and the unused funct bits are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{src, funct, mask_full};

  assign ev        = state_fetch & irdisp;
  assign mask_full = mask_of(int'(unsigned'(len_field)), MASK_W);
  assign mask      = mask_full[MASK_W-1:0];
  // The upper dispatch-address bits come from dc_field alone.
  assign addr      = dc_field | DC_W'(src[MASK_W-1:0] & mask);

  // A dispatch that arrives while a write is pending is an overrun.
  // It is discarded instead of being queued.
  assign ev_accept = ev & ~busy;
  assign wr_start  = ev_accept & funct[FUNCT_WR_BIT];

  // Next-state for the dispatch latch and the sticky overrun flag.
  always_comb begin
    dc_d         = dc_q;
    dmask_d      = dmask_q;
    disp_addr_d  = disp_addr_q;
    disp_valid_d = 1'b0;
    err_ovr_d    = err_ovr_q | (ev & busy);
    if (ev_accept) begin
      dc_d         = dc_field;
      dmask_d      = mask;
      disp_addr_d  = addr;
      disp_valid_d = ~funct[FUNCT_WR_BIT];
    end
  end

  // Dispatch latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_q         <= '0;
      dmask_q      <= '0;
      disp_addr_q  <= '0;
      disp_valid_q <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      dc_q         <= dc_d;
      dmask_q      <= dmask_d;
      disp_addr_q  <= disp_addr_d;
      disp_valid_q <= disp_valid_d;
      err_ovr_q    <= err_ovr_d;
    end
  end

  dspctl_wrseq #(
    .ADDR_W (DC_W),
    .DATA_W (SRC_W)
  ) u_wrseq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (wr_start),
    .addr    (addr),
    .data    (wr_data),
    .ack     (dmem_wr_ack),
    .busy    (busy),
    .wr_req  (dmem_wr_req),
    .wr_addr (dmem_wr_addr),
    .wr_data (dmem_wr_data),
    .stall   (stall)
  );

  assign dmapbenb   = |map_sel;
  assign dc         = dc_q;
  assign dmask      = dmask_q;
  assign disp_addr  = disp_addr_q;
  assign disp_valid = disp_valid_q;
  assign err_ovr    = err_ovr_q;

endmodule

// File: tb/tb_dspctl_gen.sv
// Directed bench for dspctl_gen.
// A scoreboard holds the expected read dispatches, and a monitor pops it on disp_valid.
module tb_dspctl_gen;
  import dspctl_pkg::*;

  localparam int DC_W   = 10;
  localparam int MASK_W = 7;
  localparam int LEN_W  = 3;
  localparam int SRC_W  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              state_fetch;
  logic              irdisp;
  logic [3:0]        funct;
  logic [DC_W-1:0]   dc_field;
  logic [LEN_W-1:0]  len_field;
  logic [1:0]        map_sel;
  logic [SRC_W-1:0]  src;
  logic [SRC_W-1:0]  wr_data;
  logic              dmem_wr_ack;
  logic [DC_W-1:0]   dc;
  logic [MASK_W-1:0] dmask;
  logic              dmapbenb;
  logic [DC_W-1:0]   disp_addr;
  logic              disp_valid;
  logic              dmem_wr_req;
  logic [DC_W-1:0]   dmem_wr_addr;
  logic [SRC_W-1:0]  dmem_wr_data;
  logic              stall;
  logic              err_ovr;

  typedef struct packed {
    logic [DC_W-1:0]   addr;
    logic [MASK_W-1:0] mask;
    logic [DC_W-1:0]   dcv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cycles = 0;

  dspctl_gen #(
    .DC_W   (DC_W),
    .MASK_W (MASK_W),
    .LEN_W  (LEN_W),
    .SRC_W  (SRC_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .state_fetch  (state_fetch),
    .irdisp       (irdisp),
    .funct        (funct),
    .dc_field     (dc_field),
    .len_field    (len_field),
    .map_sel      (map_sel),
    .src          (src),
    .wr_data      (wr_data),
    .dmem_wr_ack  (dmem_wr_ack),
    .dc           (dc),
    .dmask        (dmask),
    .dmapbenb     (dmapbenb),
    .disp_addr    (disp_addr),
    .disp_valid   (disp_valid),
    .dmem_wr_req  (dmem_wr_req),
    .dmem_wr_addr (dmem_wr_addr),
    .dmem_wr_data (dmem_wr_data),
    .stall        (stall),
    .err_ovr      (err_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic on, input logic [3:0] f, input logic [DC_W-1:0] dcf,
                        input logic [LEN_W-1:0] len, input logic [SRC_W-1:0] s);
    state_fetch = on;
    irdisp      = on;
    funct       = f;
    dc_field    = dcf;
    len_field   = len;
    src         = s;
  endtask

  task automatic push_read(input logic [DC_W-1:0] a, input logic [MASK_W-1:0] m,
                           input logic [DC_W-1:0] d);
    exp_t e;
    e.addr = a;
    e.mask = m;
    e.dcv  = d;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every disp_valid cycle must match the oldest expected read.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && dmem_wr_req === 1'b1) req_cycles++;
    if (reset_n === 1'b1 && disp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_disp_addr", 64'(disp_addr), 64'(e.addr));
        check("sb_dmask", 64'(dmask), 64'(e.mask));
        check("sb_dc", 64'(dc), 64'(e.dcv));
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    dmem_wr_ack = 1'b0;
    map_sel     = 2'b00;
    wr_data     = '0;
    set_ev(1'b0, 4'h0, '0, '0, '0);
    repeat (2) step();
    check("rst_dc", 64'(dc), 64'h0);
    check("rst_dmask", 64'(dmask), 64'h0);
    check("rst_disp_addr", 64'(disp_addr), 64'h0);
    check("rst_valid", 64'(disp_valid), 64'h0);
    check("rst_req_stall_ovr", 64'({dmem_wr_req, stall, err_ovr}), 64'h0);
    check("rst_wr_addr_data", 64'({dmem_wr_addr, dmem_wr_data}), 64'h0);
    reset_n = 1'b1;
    step();

    // dmapbenb is combinational.
    map_sel = 2'b10;
    #1 check("dmapbenb_10", 64'(dmapbenb), 64'h1);
    map_sel = 2'b00;
    #1 check("dmapbenb_00", 64'(dmapbenb), 64'h0);

    // Read dispatch: 0x200 | (0xFD & 0x07) = 0x205.
    set_ev(1'b1, 4'h0, 10'h200, 3'd3, 32'h0000_00FD);
    push_read(10'h205, 7'h07, 10'h200);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    check("rd_valid", 64'(disp_valid), 64'h1);
    check("rd_addr", 64'(disp_addr), 64'h205);
    check("rd_mask", 64'(dmask), 64'h07);
    step();
    check("rd_valid_one_cycle", 64'(disp_valid), 64'h0);

    // Mask saturation at len=7, then an empty mask at len=0.
    set_ev(1'b1, 4'h0, 10'h180, 3'd7, 32'hFFFF_FFFF);
    push_read(10'h1FF, 7'h7F, 10'h180);
    step();
    check("sat_addr", 64'(disp_addr), 64'h1FF);
    check("sat_mask", 64'(dmask), 64'h7F);
    set_ev(1'b1, 4'h0, 10'h180, 3'd0, 32'hFFFF_FFFF);
    push_read(10'h180, 7'h00, 10'h180);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    check("len0_addr", 64'(disp_addr), 64'h180);
    check("len0_mask", 64'(dmask), 64'h00);
    step();

    // Write handshake: the ack comes in the third WREQ cycle.
    req_cycles = 0;
    wr_data = 32'hDEAD_BEEF;
    set_ev(1'b1, 4'b0100, 10'h3C0, 3'd4, 32'h0000_0005);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    check("wr_c1_req_stall", 64'({dmem_wr_req, stall}), 64'h3);
    check("wr_c1_addr", 64'(dmem_wr_addr), 64'h3C5);
    check("wr_c1_data", 64'(dmem_wr_data), 64'hDEAD_BEEF);
    check("wr_c1_valid", 64'(disp_valid), 64'h0);
    check("wr_dc", 64'(dc), 64'h3C0);
    wr_data = 32'h1234_5678;
    step();
    check("wr_c2_req_stall", 64'({dmem_wr_req, stall}), 64'h3);
    // A second dispatch while the write is pending is an overrun.
    set_ev(1'b1, 4'h0, 10'h011, 3'd0, 32'h0);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    dmem_wr_ack = 1'b1;
    check("ovr_dc_kept", 64'(dc), 64'h3C0);
    check("ovr_addr_kept", 64'(disp_addr), 64'h3C5);
    check("ovr_flag", 64'(err_ovr), 64'h1);
    check("ovr_valid", 64'(disp_valid), 64'h0);
    check("wr_c3_req_stall", 64'({dmem_wr_req, stall}), 64'h3);
    check("wr_c3_held", 64'({dmem_wr_addr, dmem_wr_data}), {22'h0, 10'h3C5, 32'hDEAD_BEEF});
    step();
    dmem_wr_ack = 1'b0;
    check("wr_done_req_stall", 64'({dmem_wr_req, stall}), 64'h0);
    check("wr_req_cycles", 64'(req_cycles), 64'd3);
    check("ovr_sticky", 64'(err_ovr), 64'h1);
    // An ack seen in IDLE must not start anything.
    dmem_wr_ack = 1'b1;
    step();
    dmem_wr_ack = 1'b0;
    check("idle_ack_ignored", 64'({dmem_wr_req, stall}), 64'h0);

    // Back-to-back reads.
    set_ev(1'b1, 4'h0, 10'h001, 3'd0, 32'hFFFF_FFFF);
    push_read(10'h001, 7'h00, 10'h001);
    step();
    check("b2b_1", 64'({disp_valid, disp_addr}), 64'h401);
    set_ev(1'b1, 4'h0, 10'h002, 3'd0, 32'hFFFF_FFFF);
    push_read(10'h002, 7'h00, 10'h002);
    step();
    check("b2b_2", 64'({disp_valid, disp_addr}), 64'h402);
    set_ev(1'b1, 4'h0, 10'h004, 3'd0, 32'hFFFF_FFFF);
    push_read(10'h004, 7'h00, 10'h004);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    check("b2b_3", 64'({disp_valid, disp_addr}), 64'h404);
    step();
    check("b2b_end_valid", 64'(disp_valid), 64'h0);
    check("ovr_still_set", 64'(err_ovr), 64'h1);

    // Asynchronous reset in the middle of a write.
    set_ev(1'b1, 4'b0100, 10'h100, 3'd0, 32'h0);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    check("pre_rst_req", 64'(dmem_wr_req), 64'h1);
    #2 reset_n = 1'b0;
    #1 check("async_rst_req_stall_ovr", 64'({dmem_wr_req, stall, err_ovr}), 64'h0);
    check("async_rst_dc", 64'(dc), 64'h0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_idle", 64'({dmem_wr_req, stall}), 64'h0);

    // After reset the sequencer is idle and accepts a write.
    // With ack already high this gives the one-cycle minimum occupancy.
    wr_data = 32'hCAFE_0001;
    dmem_wr_ack = 1'b1;
    set_ev(1'b1, 4'b0100, 10'h040, 3'd2, 32'h3);
    step();
    set_ev(1'b0, 4'h0, '0, '0, '0);
    check("min_wr_req", 64'({dmem_wr_req, stall}), 64'h3);
    check("min_wr_addr", 64'(dmem_wr_addr), 64'h043);
    step();
    dmem_wr_ack = 1'b0;
    check("min_wr_done", 64'({dmem_wr_req, stall}), 64'h0);
    check("min_wr_no_ovr", 64'(err_ovr), 64'h0);
    step();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
